// File: rtl/tx_pkt_framer_pkg.sv
// Shared constants and state encoding for the TX framer and its RX counterparts.
// The payload size and sync word must stay identical on both sides of the link.
package tx_pkt_framer_pkg;

   localparam int         TX_PAYLOAD_BYTES = 3;
   localparam int         TX_PREAMBLE_BITS = 8;
   localparam int         TX_SYNC_LEN      = 8;
   localparam logic [7:0] TX_SYNC_WORD     = 8'hA7;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_PREAMBLE = 3'd2,
      ST_SYNC     = 3'd3,
      ST_PAYLOAD  = 3'd4
   } tx_state_e;

   // Index width that stays legal when only a single entry exists.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_pkt_framer_payload_buf.sv
// Payload register file: one byte write port and a combinational bit-select read.
// Contents survive abort so only reset clears them.
module tx_payload_buf
   import tx_pkt_framer_pkg::*;
#(
   parameter int PAYLOAD_BYTES = TX_PAYLOAD_BYTES,
   parameter int IDX_W         = idx_width(PAYLOAD_BYTES)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [7:0]       i_wr_data,
   input  logic [IDX_W-1:0] i_rd_byte,
   input  logic [2:0]       i_rd_bit,
   output logic             o_rd_bit
);

   logic [7:0] r_mem [PAYLOAD_BYTES];

   // Byte storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_bit = r_mem[i_rd_byte][i_rd_bit];

endmodule

// File: rtl/tx_pkt_framer.sv
// Collects a payload over valid/ready and serialises preamble, sync word and payload
// MSB first on tx_out, one bit per bit_en strobe.
module tx_pkt_framer
   import tx_pkt_framer_pkg::*;
#(
   parameter int                  PAYLOAD_BYTES = TX_PAYLOAD_BYTES,
   parameter int                  PREAMBLE_BITS = TX_PREAMBLE_BITS,
   parameter int                  SYNC_LEN      = TX_SYNC_LEN,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD     = TX_SYNC_WORD
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_en,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic       abort,
   output logic       tx_out,
   output logic       busy,
   output logic       pkt_sent
);

   localparam int CNT_MAX = (PREAMBLE_BITS > SYNC_LEN) ? PREAMBLE_BITS : SYNC_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = idx_width(PAYLOAD_BYTES);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [CNT_W-1:0] PRE_END  = CNT_W'(PREAMBLE_BITS);
   localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_LEN);
   localparam logic [CNT_W-1:0] SYNC_TOP = CNT_W'(SYNC_LEN - 1);

   tx_state_e        r_state;
   logic             r_tx_out;
   logic             r_busy;
   logic             r_byte_ready;
   logic             r_pkt_sent;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [IDX_W-1:0] r_wr_idx;
   logic [IDX_W-1:0] r_byte_idx;
   logic [2:0]       r_bit_idx;

   tx_state_e        w_state_nxt;
   logic             w_tx_nxt;
   logic             w_pkt_nxt;
   logic [CNT_W-1:0] w_bit_cnt_nxt;
   logic [IDX_W-1:0] w_wr_idx_nxt;
   logic [IDX_W-1:0] w_byte_idx_nxt;
   logic [2:0]       w_bit_idx_nxt;
   logic [IDX_W-1:0] w_rd_byte;
   logic [2:0]       w_rd_bit;
   logic             w_buf_bit;
   logic             w_accept;
   logic             w_last_bit;
   logic [SYNC_LEN-1:0] w_sync_vec;

   assign w_accept   = byte_valid && r_byte_ready && !abort;
   assign w_last_bit = (r_byte_idx == LAST_IDX) && (r_bit_idx == 3'd0);
   assign w_sync_vec = SYNC_WORD >> (SYNC_TOP - r_bit_cnt);

   tx_payload_buf #(
      .PAYLOAD_BYTES (PAYLOAD_BYTES),
      .IDX_W         (IDX_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_accept),
      .i_wr_idx  (r_wr_idx),
      .i_wr_data (byte_in),
      .i_rd_byte (w_rd_byte),
      .i_rd_bit  (w_rd_bit),
      .o_rd_bit  (w_buf_bit)
   );

   // Payload bit pointer for the next strobe; the first payload bit is byte 0, bit 7.
   always_comb begin
      w_rd_byte = '0;
      w_rd_bit  = 3'd7;
      if (r_state == ST_PAYLOAD) begin
         if (r_bit_idx != 3'd0) begin
            w_rd_byte = r_byte_idx;
            w_rd_bit  = r_bit_idx - 3'd1;
         end else if (r_byte_idx != LAST_IDX) begin
            w_rd_byte = r_byte_idx + IDX_W'(1);
            w_rd_bit  = 3'd7;
         end else begin
            w_rd_byte = r_byte_idx;
            w_rd_bit  = 3'd0;
         end
      end else begin
         w_rd_byte = '0;
         w_rd_bit  = 3'd7;
      end
   end

   // Next-state and datapath decode; abort overrides strobes and byte writes.
   always_comb begin
      w_state_nxt    = r_state;
      w_tx_nxt       = r_tx_out;
      w_pkt_nxt      = 1'b0;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_wr_idx_nxt   = r_wr_idx;
      w_byte_idx_nxt = r_byte_idx;
      w_bit_idx_nxt  = r_bit_idx;
      if (abort) begin
         w_state_nxt   = ST_IDLE;
         w_tx_nxt      = 1'b0;
         w_bit_cnt_nxt = '0;
         w_wr_idx_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_tx_nxt = 1'b0;
               if (w_accept) begin
                  if (r_wr_idx == LAST_IDX) begin
                     w_state_nxt  = ST_ARMED;
                     w_wr_idx_nxt = '0;
                  end else begin
                     w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
                  end
               end
            end
            ST_ARMED: begin
               if (bit_en) begin
                  w_tx_nxt      = 1'b1;
                  w_bit_cnt_nxt = CNT_W'(1);
                  w_state_nxt   = ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               if (bit_en) begin
                  if (r_bit_cnt == PRE_END) begin
                     w_tx_nxt      = SYNC_WORD[SYNC_LEN-1];
                     w_bit_cnt_nxt = CNT_W'(1);
                     w_state_nxt   = ST_SYNC;
                  end else begin
                     w_tx_nxt      = ~r_bit_cnt[0];
                     w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_SYNC: begin
               if (bit_en) begin
                  if (r_bit_cnt == SYNC_END) begin
                     w_tx_nxt       = w_buf_bit;
                     w_byte_idx_nxt = w_rd_byte;
                     w_bit_idx_nxt  = w_rd_bit;
                     w_bit_cnt_nxt  = '0;
                     w_state_nxt    = ST_PAYLOAD;
                  end else begin
                     w_tx_nxt      = w_sync_vec[0];
                     w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_PAYLOAD: begin
               if (bit_en) begin
                  if (w_last_bit) begin
                     w_tx_nxt    = 1'b0;
                     w_pkt_nxt   = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_tx_nxt       = w_buf_bit;
                     w_byte_idx_nxt = w_rd_byte;
                     w_bit_idx_nxt  = w_rd_bit;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_tx_nxt    = 1'b0;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_tx_out     <= 1'b0;
         r_busy       <= 1'b0;
         r_byte_ready <= 1'b0;
         r_pkt_sent   <= 1'b0;
         r_bit_cnt    <= '0;
         r_wr_idx     <= '0;
         r_byte_idx   <= '0;
         r_bit_idx    <= 3'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_tx_out     <= w_tx_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         // Ready only after a full cycle in IDLE, so it never overlaps ARMED.
         r_byte_ready <= (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE);
         r_pkt_sent   <= w_pkt_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_wr_idx     <= w_wr_idx_nxt;
         r_byte_idx   <= w_byte_idx_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
      end
   end

   assign tx_out     = r_tx_out;
   assign busy       = r_busy;
   assign byte_ready = r_byte_ready;
   assign pkt_sent   = r_pkt_sent;

endmodule

// File: tb/tb_tx_pkt_framer.sv
// Scoreboard bench: the driver steps a strobe-count reference model and queues the
// expected outputs; an independent monitor compares them after every clock edge.
module tb_tx_pkt_framer;

   localparam int         P   = 3;
   localparam int         PRE = 8;
   localparam int         SL  = 8;
   localparam int         N   = PRE + SL + 8 * P;
   localparam int         W   = 8 * P;
   localparam logic [7:0] SW  = 8'hA7;

   logic       clk = 1'b0;
   logic       rst, bit_en, byte_valid, abort;
   logic [7:0] byte_in;
   logic       byte_ready, tx_out, busy, pkt_sent;

   always #5 clk = ~clk;

   tx_pkt_framer dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .abort      (abort),
      .tx_out     (tx_out),
      .busy       (busy),
      .pkt_sent   (pkt_sent)
   );

   int n_vec = 0, n_err = 0, cyc = 0, mode = 0, pkts_dut = 0, pkts_exp = 0;

   // reference model: fill count, strobes consumed since the payload was complete
   bit          m_txing, m_acc, m_tx, m_busy, m_rdy, m_pkt;
   int          m_cnt, m_k;
   logic [W-1:0] m_pay;
   logic [3:0]  exp_q [$];

   function automatic bit fbit(input int i);
      logic [7:0]   s;
      logic [W-1:0] p;
      if (i < PRE) return (i % 2) == 0;
      if (i < PRE + SL) begin
         s = SW >> (SL - 1 - (i - PRE));
         return s[0];
      end
      p = m_pay >> (W - 1 - (i - PRE - SL));
      return p[0];
   endfunction

   task automatic model_step(input bit r, input bit ab, input bit be, input bit v, input logic [7:0] d);
      bit           was_fill;
      int           sh;
      logic [W-1:0] mask;
      m_acc = 1'b0;
      m_pkt = 1'b0;
      if (!r) begin
         m_txing = 1'b0; m_cnt = 0; m_k = 0; m_pay = '0;
         m_tx = 1'b0; m_busy = 1'b0; m_rdy = 1'b0;
      end else begin
         was_fill = !m_txing;
         if (ab) begin
            m_txing = 1'b0; m_cnt = 0; m_k = 0; m_tx = 1'b0;
         end else if (!m_txing) begin
            m_tx = 1'b0;
            if (v && m_rdy) begin
               m_acc = 1'b1;
               sh    = 8 * (P - 1 - m_cnt);
               mask  = W'(8'hFF) << sh;
               m_pay = (m_pay & ~mask) | (W'(d) << sh);
               m_cnt++;
               if (m_cnt == P) begin
                  m_txing = 1'b1; m_cnt = 0; m_k = 0;
               end
            end
         end else if (be) begin
            m_k++;
            if (m_k <= N) m_tx = fbit(m_k - 1);
            else begin
               m_tx = 1'b0; m_pkt = 1'b1; m_txing = 1'b0; m_k = 0; pkts_exp++;
            end
         end
         m_rdy  = was_fill && !m_txing;
         m_busy = m_txing;
      end
      exp_q.push_back({m_tx, m_busy, m_rdy, m_pkt});
   endtask

   task automatic step(input bit r, input bit ab, input bit v, input logic [7:0] d);
      bit be;
      case (mode)
         0:       be = ((cyc % 4) == 3);
         1:       be = 1'b1;
         default: be = ($urandom_range(2) == 0);
      endcase
      rst = r; abort = ab; byte_valid = v; byte_in = d; bit_en = be;
      model_step(r, ab, be, v, d);
      cyc++;
      @(negedge clk);
   endtask

   task automatic fill(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] bs [3];
      int         tries;
      bs = '{b0, b1, b2};
      for (int i = 0; i < P; i++) begin
         tries = 0;
         do begin
            step(1'b1, 1'b0, 1'b1, bs[i]);
            tries++;
         end while (!m_acc && tries < 50);
         if (!m_acc) begin
            n_vec++; n_err++;
            $display("FAIL fill_timeout byte %0d not accepted within 50 cycles", i);
         end
      end
   endtask

   task automatic run(input int abort_at, input bit stray, input int rst_at);
      int budget;
      budget = 0;
      while (m_txing && budget < 2000) begin
         if (abort_at > 0 && m_k == abort_at) step(1'b1, 1'b1, stray, 8'hFF);
         else if (rst_at > 0 && m_k == rst_at) step(1'b0, 1'b0, 1'b0, 8'h00);
         else step(1'b1, 1'b0, stray && ($urandom_range(1) == 1), 8'hFF);
         budget++;
      end
      if (m_txing) begin
         n_vec++; n_err++;
         $display("FAIL frame_timeout still transmitting after %0d cycles", budget);
      end
   endtask

   // monitor: one expected output word per clock edge
   initial begin
      logic [3:0] got, want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {tx_out, busy, byte_ready, pkt_sent};
            n_vec++;
            if (got !== want) begin
               n_err++;
               $display("FAIL outputs t=%0t cyc=%0d {tx,busy,rdy,pkt} got %b want %b", $time, cyc, got, want);
            end
            if (pkt_sent === 1'b1) pkts_dut++;
         end
      end
   end

   initial begin
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);

      mode = 0; fill(8'h12, 8'h34, 8'h56); run(0, 1'b0, 0);
      fill(8'h3C, 8'hC3, 8'h81);            run(0, 1'b1, 0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
      fill(8'h9E, 8'h01, 8'h7F);            run(20, 1'b0, 0);
      fill(8'hAA, 8'h55, 8'h00);            run(0, 1'b0, 0);
      fill(8'hDE, 8'hAD, 8'hBE);            run(0, 1'b0, 12);
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
      mode = 1; fill(8'hF0, 8'h0F, 8'hE1);  run(0, 1'b0, 0);

      mode = 0;
      step(1'b1, 1'b0, 1'b1, 8'h11);
      step(1'b1, 1'b1, 1'b1, 8'h77);
      fill(8'h5A, 8'hA5, 8'hC6);            run(0, 1'b0, 0);

      for (int f = 0; f < 10; f++) begin
         mode = int'($urandom_range(2));
         fill(8'($urandom), 8'($urandom), 8'($urandom));
         run(($urandom_range(3) == 0) ? int'($urandom_range(40, 1)) : 0,
             1'($urandom_range(1)), 0);
         repeat (int'($urandom_range(3))) step(1'b1, 1'b0, 1'b0, 8'h00);
      end
      repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00);

      n_vec++;
      if (pkts_dut != pkts_exp) begin
         n_err++;
         $display("FAIL pkt_count got %0d want %0d", pkts_dut, pkts_exp);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tx_pkt_framer.md
Name: tx_pkt_framer

Overview:
- Transmit-side counterpart of the RX shift-buffer/packet-detect path.
- Collects PAYLOAD_BYTES bytes from the SPI receive side over a valid/ready interface.
- Serialises a framed packet onto tx_out, one bit per bit_en strobe (the same bit-rate enable that drives the RX shift path): preamble, then sync word, then payload, all MSB first.
- Output feeds the TX_OUT OR with the external bypass.

Parameters:
- PAYLOAD_BYTES, 3, payload bytes per packet (matches the 24-bit RX packet).
- PREAMBLE_BITS, 8, length of the alternating 1010… preamble, starting with 1.
- SYNC_WORD, 8'hA7, sync pattern sent MSB first after the preamble.
- SYNC_LEN, 8, width of SYNC_WORD.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- bit_en  in  1  one-cycle bit-rate strobe; each strobe advances one bit
- byte_in  in  8  payload byte from the SPI slave
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  framer accepts a byte this cycle
- abort  in  1  drop the current fill or frame and return to IDLE
- tx_out  out  1  registered serial output; 0 when not transmitting
- busy  out  1  high in ARMED, PREAMBLE, SYNC and PAYLOAD
- pkt_sent  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset: all state is cleared on a clk edge with rst==0.
  - state=IDLE, wr_idx=0, bit_cnt=0.
  - tx_out=0, busy=0, pkt_sent=0, byte_ready=0.
  - Payload registers are cleared to 0.
  - Reset mid-frame truncates the frame; the next frame needs a full refill.
- States: IDLE (filling), ARMED, PREAMBLE, SYNC, PAYLOAD.
- byte_ready: registered; equals 1 only in IDLE, and only from the cycle after reset is released.
- IDLE:
  - Each cycle with byte_valid&&byte_ready writes buf[wr_idx]=byte_in and increments wr_idx.
  - Accepting byte PAYLOAD_BYTES-1: go to ARMED, byte_ready=0 on the next cycle, wr_idx=0.
  - bit_en is ignored in IDLE; tx_out=0.
- ARMED: on the first bit_en, tx_out<=1 (preamble bit 0), bit_cnt<=1, state=PREAMBLE.
- Bit timing:
  - tx_out changes only on cycles where bit_en=1.
  - Each bit is held until the next bit_en.
  - Zero added latency: the bit emitted on the strobe is visible the cycle after that strobe.
- PREAMBLE:
  - On each bit_en, emit bit bit_cnt of the preamble (bit i = ~i[0]).
  - After PREAMBLE_BITS bits, the next bit_en emits SYNC_WORD[SYNC_LEN-1] and enters SYNC with bit_cnt reset.
- SYNC: emit SYNC_WORD bits MSB→LSB, then enter PAYLOAD.
- PAYLOAD: emit buf[0] MSB first through buf[PAYLOAD_BYTES-1] LSB, using a byte index and a 3-bit bit index.
- Frame completion:
  - Total bits N = PREAMBLE_BITS+SYNC_LEN+8*PAYLOAD_BYTES (40 by default).
  - The bit_en after bit N-1 sets tx_out<=0, pulses pkt_sent for one cycle, and sets state=IDLE.
  - byte_ready rises on the following cycle.
  - A frame therefore consumes N+1 strobes from ARMED.
- Counters:
  - bit_cnt is wide enough for max(PREAMBLE_BITS,SYNC_LEN); it never wraps inside a field.
  - wr_idx and the byte index are $clog2(PAYLOAD_BYTES) bits wide and saturate at PAYLOAD_BYTES-1 by construction.
- Full/ignore: byte_valid while byte_ready=0 is ignored; there is no queueing and no overwrite.
- abort:
  - Takes effect in any state on the next edge: state=IDLE, wr_idx=0, tx_out=0, no pkt_sent.
  - abort has priority over bit_en and over a byte write in the same cycle; that byte is dropped.
- Simultaneous events:
  - A bit_en coincident with the final byte write in IDLE is not consumed.
  - Transmission starts on the next bit_en after entering ARMED.
- busy: registered, equal to (state≠IDLE).

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, ARMED, PREAMBLE, SYNC, PAYLOAD);
  - default SYNC_WORD and SYNC_LEN, shared with the RX sync detector;
  - PAYLOAD_BYTES, shared with the RX shift buffer and packet register.
- One natural sub-module: tx_payload_buf, the PAYLOAD_BYTES×8 register file with a write port and an indexed bit-read mux.
- The FSM, counters and tx_out register stay in tx_pkt_framer.

Test Plan:
- Write 0x12,0x34,0x56 back-to-back, bit_en every 4 cycles → tx_out sampled at the strobes = 10101010 10100111 00010010 00110100 01010110; pkt_sent on the 41st strobe after ARMED; byte_ready high one cycle later.
- Present byte_valid with 0xFF during PAYLOAD → byte_ready=0; the 0xFF is not captured; the next frame sends only the newly written bytes.
- Assert abort on strobe 20 (inside PAYLOAD) → tx_out=0 next cycle, no pkt_sent, busy=0, wr_idx=0; a refill of 0xAA,0x55,0x00 then produces a complete correct frame.
- Drive rst=0 for one cycle mid-SYNC → all outputs 0 on that edge; byte_ready=1 one cycle after release; the old payload reads back as 0x00.
- Assert bit_en in the same cycle as the 3rd byte write → no bit emitted; the first preamble 1 appears after the next strobe.
- Hold bit_en high continuously → one bit per clk; 40 payload+header bits, then pkt_sent at cycle 41 after ARMED.
